// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and enums for the config video buffer writer.
package cfg_pkg;
  localparam int BUF_COLS = 40;
  localparam int BUF_ROWS = 23;
  typedef enum logic {CFG_OP_COPY = 1'b0, CFG_OP_FILL = 1'b1} cfg_op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} cfg_wr_state_t;
endpackage

// File: rtl/cfg_valid_delay.sv
// cfg_valid_delay: DEPTH-stage shift register of {valid, addr}; reset clears valids only.
module cfg_valid_delay #(
  parameter int DEPTH = 2,
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] addr_i,
  output logic         valid_o,
  output logic [W-1:0] addr_o
);
  logic [DEPTH-1:0] v_q;
  logic [W-1:0]     a_q [DEPTH];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
    end else begin
      v_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    a_q[0] <= addr_i;
    for (int i = 1; i < DEPTH; i++) a_q[i] <= a_q[i-1];
  end
  assign valid_o = v_q[DEPTH-1];
  assign addr_o  = a_q[DEPTH-1];
endmodule

// File: rtl/cfg_buffer_writer.sv
// cfg_buffer_writer: command-driven COPY/FILL writer for the 40x23 config video buffer.
module cfg_buffer_writer
  import cfg_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic        cmd_op_in,
  input  logic [11:0] cmd_src_in,
  input  logic [7:0]  cmd_fill_in,
  input  logic [4:0]  cmd_row_in,
  input  logic [5:0]  cmd_col_in,
  input  logic [5:0]  cmd_len_in,
  output logic [11:0] menu_addr_out,
  input  logic [7:0]  menu_tile_in,
  output logic        buf_write_valid_out,
  output logic [9:0]  buf_write_addr_out,
  output logic [7:0]  buf_write_data_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);
  cfg_wr_state_t state_q;
  cfg_op_t       op_q;
  logic [7:0]    fill_q;
  logic [9:0]    wa_q;
  logic [5:0]    rem_q;
  logic [11:0]   addr_q;
  logic          err_q;
  logic          bad, pv, fv;
  logic [6:0]    room;
  logic [5:0]    n;
  logic [9:0]    pa;
  always_comb begin
    bad  = cmd_row_in >= 5'(BUF_ROWS) || cmd_col_in >= 6'(BUF_COLS);
    room = 7'(BUF_COLS) - 7'(cmd_col_in);
    n    = 7'(cmd_len_in) < room ? cmd_len_in : room[5:0];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      op_q    <= CFG_OP_COPY;
      fill_q  <= '0;
      wa_q    <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_in) begin
          op_q    <= cfg_op_t'(cmd_op_in);
          fill_q  <= cmd_fill_in;
          wa_q    <= 10'(cmd_row_in) * 10'(BUF_COLS) + 10'(cmd_col_in);
          rem_q   <= n;
          err_q   <= bad;
          state_q <= (bad || n == 6'd0) ? DONE : ISSUE;
          if (cfg_op_t'(cmd_op_in) == CFG_OP_COPY) addr_q <= cmd_src_in;
        end
        ISSUE: if (rem_q == 6'd1) begin
          state_q <= op_q == CFG_OP_COPY ? DRAIN : DONE;
          rem_q   <= 6'(READ_LATENCY);
        end else begin
          rem_q  <= rem_q - 6'd1;
          wa_q   <= wa_q + 10'd1;
          addr_q <= op_q == CFG_OP_COPY ? addr_q + 12'd1 : addr_q;
        end
        DRAIN: if (rem_q == 6'd1) state_q <= DONE;
               else rem_q <= rem_q - 6'd1;
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // COPY elements wait READ_LATENCY cycles for their tile; FILL writes straight from the issue slot
  cfg_valid_delay #(.DEPTH(READ_LATENCY), .W(10)) u_dly (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .valid_i(state_q == ISSUE && op_q == CFG_OP_COPY),
    .addr_i (wa_q),
    .valid_o(pv),
    .addr_o (pa)
  );
  always_comb begin
    fv                  = state_q == ISSUE && op_q == CFG_OP_FILL;
    buf_write_valid_out = pv | fv;
    buf_write_addr_out  = fv ? wa_q : pa;
    buf_write_data_out  = op_q == CFG_OP_FILL ? fill_q : menu_tile_in;
    menu_addr_out       = addr_q;
    cmd_ready_out       = state_q == IDLE;
    busy_out            = state_q != IDLE;
    done_out            = state_q == DONE;
    err_out             = state_q == DONE && err_q;
  end
endmodule

// File: tb/tb_cfg_buffer_writer.sv
// tb_cfg_buffer_writer: table-driven commands with a write scoreboard and a 2-cycle menu memory model.
module tb_cfg_buffer_writer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready;
  logic [11:0] cmd_src = '0, menu_addr;
  logic [7:0]  cmd_fill = '0, menu_tile, wd;
  logic [4:0]  cmd_row = '0;
  logic [5:0]  cmd_col = '0, cmd_len = '0;
  logic        wv, busy, done, err;
  logic [9:0]  wa;
  logic [7:0]  mem [4096];
  logic [7:0]  r1, r2;
  typedef struct {int c; logic [9:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic op; logic [11:0] src; logic [7:0] fill; logic [4:0] row; logic [5:0] col, len; int n; logic err;} vec_t;
  wr_t  q[$];
  vec_t vt[9];
  int   cyc = 0, nchk = 0, nfail = 0, nwr = 0;

  cfg_buffer_writer dut (
    .clk_in(clk), .rst_in(rst), .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_op_in(cmd_op), .cmd_src_in(cmd_src), .cmd_fill_in(cmd_fill), .cmd_row_in(cmd_row),
    .cmd_col_in(cmd_col), .cmd_len_in(cmd_len), .menu_addr_out(menu_addr), .menu_tile_in(menu_tile),
    .buf_write_valid_out(wv), .buf_write_addr_out(wa), .buf_write_data_out(wd),
    .busy_out(busy), .done_out(done), .err_out(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    r1  <= mem[menu_addr];
    r2  <= r1;
  end
  assign menu_tile = r2;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every negedge passes through here so the write scoreboard sees each cycle.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (wv) begin
      nwr++;
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL write_unexpected: addr=%0d data=%0h cycle %0d", wa, wd, cyc);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.a != wa || e.d != wd) begin
          nfail++;
          $display("FAIL write: got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
                   cyc, wa, wd, e.c, e.a, e.d);
        end
      end
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_op = v.op; cmd_src = v.src; cmd_fill = v.fill;
    cmd_row = v.row; cmd_col = v.col; cmd_len = v.len;
  endtask

  task automatic push(input vec_t v, input int a0);
    wr_t e;
    for (int k = 0; k < v.n; k++) begin
      e.c = a0 + 1 + k + (v.op ? 0 : 2);
      e.a = 10'(int'(v.row) * 40 + int'(v.col) + k);
      e.d = v.op ? v.fill : mem[(int'(v.src) + k) & 12'hfff];
      q.push_back(e);
    end
  endtask

  task automatic run(input vec_t v);
    int a0, w0, t;
    step();
    drive(v);
    cmd_valid = 1'b1;
    a0 = cyc;
    w0 = nwr;
    chk("ready_idle", int'(cmd_ready), 1);
    push(v, a0);
    step();
    cmd_valid = 1'b0;
    t = 0;
    while (!done && t < 200) begin
      step();
      t++;
    end
    chk("done_cycle", done ? cyc - a0 : -1, v.n == 0 ? 1 : v.op ? v.n + 1 : v.n + 3);
    chk("err", int'(err), int'(v.err));
    chk("busy_at_done", int'(busy), 1);
    step();
    chk("ready_after", int'(cmd_ready), 1);
    chk("busy_after", int'(busy), 0);
    chk("nwrites", nwr - w0, v.n);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    int a0;
    vec_t va, vb;
    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 4));
    vt[0] = '{1'b0, 12'h100, 8'h00, 5'd2,  6'd5,  6'd4,  4,  1'b0};
    vt[1] = '{1'b1, 12'h000, 8'h20, 5'd22, 6'd0,  6'd40, 40, 1'b0};
    vt[2] = '{1'b0, 12'h200, 8'h00, 5'd0,  6'd38, 6'd5,  2,  1'b0};
    vt[3] = '{1'b1, 12'h000, 8'h33, 5'd23, 6'd0,  6'd5,  0,  1'b1};
    vt[4] = '{1'b0, 12'h010, 8'h00, 5'd0,  6'd40, 6'd3,  0,  1'b1};
    vt[5] = '{1'b0, 12'h020, 8'h00, 5'd1,  6'd1,  6'd0,  0,  1'b0};
    vt[6] = '{1'b0, 12'hffe, 8'h00, 5'd10, 6'd0,  6'd4,  4,  1'b0};
    vt[7] = '{1'b1, 12'h000, 8'ha5, 5'd5,  6'd39, 6'd63, 1,  1'b0};
    vt[8] = '{1'b0, 12'h000, 8'h00, 5'd31, 6'd63, 6'd9,  0,  1'b1};
    step();
    step();
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wv", int'(wv), 0);
    chk("rst_menu_addr", int'(menu_addr), 0);
    rst = 1'b0;
    foreach (vt[i]) run(vt[i]);
    // second command held valid while the first is busy
    va = '{1'b0, 12'h040, 8'h00, 5'd3, 6'd0,  6'd3, 3, 1'b0};
    vb = '{1'b1, 12'h000, 8'h77, 5'd4, 6'd10, 6'd2, 2, 1'b0};
    step();
    drive(va);
    cmd_valid = 1'b1;
    a0 = cyc;
    push(va, a0);
    step();
    drive(vb);
    push(vb, a0 + 7);
    for (int i = 1; i < 7; i++) begin
      chk("ready_busy", int'(cmd_ready), 0);
      if (i < 6) step();
    end
    chk("hold_doneA", int'(done), 1);
    step();
    chk("hold_readyB", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("hold_busyB", int'(busy), 1);
    step();
    step();
    chk("hold_doneB", int'(done), 1);
    chk("hold_errB", int'(err), 0);
    step();
    chk("hold_queue", q.size(), 0);
    // reset asserted while a COPY has writes in flight
    va = '{1'b0, 12'h300, 8'h00, 5'd7, 6'd2, 6'd6, 1, 1'b0};
    step();
    drive(va);
    cmd_valid = 1'b1;
    a0 = cyc;
    push(va, a0);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("midrst_wv_before", int'(wv), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wv", int'(wv), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("midrst_queue", q.size(), 0);
    chk("midrst_ready_after", int'(cmd_ready), 1);
    run(vt[0]);
    run(vt[7]);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
